// File: rtl/debug_overlay_snap_pkg.sv
// Shared fixed-point parameters and overlay colour constants.
//   Qm/Qn/Qmn : integer, fraction and total bits of a displayed channel
//   COL_*     : 2-bit overlay intensities, replicated onto R, G and B
//   ch_row()  : overlay row that carries channel k (every third row blank)
package debug_overlay_snap_pkg;

  localparam int unsigned Qm  = 6;
  localparam int unsigned Qn  = 10;
  localparam int unsigned Qmn = Qm + Qn;

  localparam logic [1:0] COL_GRID = 2'b00;
  localparam logic [1:0] COL_DIV  = 2'b10;
  localparam logic [1:0] COL_ONE  = 2'b11;
  localparam logic [1:0] COL_ZERO = 2'b01;

  // Changed-bit highlights (red), used only when diffing snapshots.
  localparam logic [5:0] RGB_DIFF_SET = 6'b110000;
  localparam logic [5:0] RGB_DIFF_CLR = 6'b010000;

  function automatic logic [5:0] grey3(input logic [1:0] c);
    return {c, c, c};
  endfunction

  function automatic int unsigned ch_row(input int unsigned k);
    return k + k / 2;
  endfunction

endpackage

// File: rtl/debug_overlay_snap_row_map.sv
// debug_row_map: overlay row index -> channel valid + channel index.
//   row        : cell row (vpos >> DEBUG_SCALE)
//   ch_valid_c : row carries a channel (not a blank separator row)
//   ch_idx_c   : channel shown on that row
module debug_row_map
  import debug_overlay_snap_pkg::*;
#(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned ROW_W  = 7,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [ROW_W-1:0] row,
  output logic             ch_valid_c,
  output logic [IDX_W-1:0] ch_idx_c
);

  // Match the row against every channel's fixed row position.
  always_comb begin
    ch_valid_c = 1'b0;
    ch_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (row == ROW_W'(ch_row(k))) begin
        ch_valid_c = 1'b1;
        ch_idx_c   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/debug_overlay_snap.sv
// debug_overlay_snap: per-frame snapshotted binary debug overlay drawn in the
// top-right corner of the view, one registered pipeline stage.
//   clk, rst_n       : pixel clock, async active-low reset
//   hpos, vpos       : current pixel position
//   frame_start      : start-of-frame pulse; loads the snapshot unless freeze
//   freeze           : hold the displayed values
//   ch_data          : NUM_CH channels of CH_W bits, channel k at [k*CH_W +: CH_W]
//   in_debug_overlay : previous-cycle pixel lies inside the overlay
//   debug_rgb        : previous-cycle overlay colour {R,G,B} x 2 bits
// Optional: define DEBUG_OVERLAY_DIFF_EN to highlight bits that changed
// between the two most recent snapshots.
module debug_overlay_snap
  import debug_overlay_snap_pkg::*;
#(
  parameter int unsigned H_VIEW      = 640,
  parameter int unsigned DEBUG_SCALE = 3,
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned CH_W        = Qmn,
  parameter int unsigned INT_W       = Qm
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     frame_start,
  input  logic                     freeze,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic                     in_debug_overlay,
  output logic [5:0]               debug_rgb
);

  localparam int unsigned OV_W  = CH_W << DEBUG_SCALE;
  localparam int unsigned HS    = H_VIEW - OV_W - 1;
  localparam int unsigned ROWS  = ch_row(NUM_CH - 1) + 1;
  localparam int unsigned OV_H  = ROWS << DEBUG_SCALE;
  localparam int unsigned DIV_H = INT_W << DEBUG_SCALE;
  localparam int unsigned ROW_W = 10 - DEBUG_SCALE;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BIT_W = (CH_W > 1) ? $clog2(CH_W) : 1;

  logic              load_c;
  logic [CH_W-1:0]   snap_q [NUM_CH];
  logic [CH_W-1:0]   snap_d [NUM_CH];
  logic              in_ov_q, in_ov_d;
  logic [5:0]        rgb_q, rgb_d;

  logic [10:0]       h_c;
  logic              inside_c;
  logic              grid_c;
  logic              ch_valid_c;
  logic [IDX_W-1:0]  ch_idx_c;
  logic [BIT_W-1:0]  bit_idx_c;
  logic [CH_W-1:0]   word_c;
  logic              bit_c;
  logic [1:0]        col_c;

  assign load_c = frame_start & ~freeze;

  // Snapshot bank: loaded only on accepted frame starts.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      snap_d[k] = load_c ? ch_data[k*CH_W +: CH_W] : snap_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) snap_q[k] <= snap_d[k];
    end
  end

`ifdef DEBUG_OVERLAY_DIFF_EN
  logic [CH_W-1:0] prev_q [NUM_CH];
  logic [CH_W-1:0] prev_d [NUM_CH];
  logic [CH_W-1:0] prev_word_c;

  // Previous snapshot takes the outgoing current snapshot on each load.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      prev_d[k] = load_c ? snap_q[k] : prev_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) prev_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) prev_q[k] <= prev_d[k];
    end
  end
`endif

  // Overlay-relative position; a negative h sets bit 10.
  always_comb begin
    h_c      = {1'b0, hpos} - 11'(HS);
    inside_c = ~h_c[10] && (h_c <= 11'(OV_W)) && (vpos <= 10'(OV_H));
    grid_c   = (h_c[DEBUG_SCALE-1:0] == '0) || (vpos[DEBUG_SCALE-1:0] == '0);
  end

  debug_row_map #(
    .NUM_CH (NUM_CH),
    .ROW_W  (ROW_W),
    .IDX_W  (IDX_W)
  ) u_row_map (
    .row        (vpos[9:DEBUG_SCALE]),
    .ch_valid_c (ch_valid_c),
    .ch_idx_c   (ch_idx_c)
  );

  // MSB of the channel sits in the leftmost cell.
  always_comb begin
    bit_idx_c = BIT_W'(CH_W - 1) - BIT_W'(h_c >> DEBUG_SCALE);
    word_c    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_idx_c == IDX_W'(k)) word_c = snap_q[k];
    end
    bit_c = word_c[bit_idx_c];
  end

`ifdef DEBUG_OVERLAY_DIFF_EN
  always_comb begin
    prev_word_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_idx_c == IDX_W'(k)) prev_word_c = prev_q[k];
    end
  end
`endif

  // Colour priority: gridline/divider, then data cell, then blank row.
  always_comb begin
    col_c   = COL_GRID;
    in_ov_d = inside_c;
    rgb_d   = '0;
    if (grid_c) begin
      col_c = (h_c == 11'(DIV_H)) ? COL_DIV : COL_GRID;
    end else if (ch_valid_c) begin
      col_c = bit_c ? COL_ONE : COL_ZERO;
    end
    if (inside_c) begin
      rgb_d = grey3(col_c);
`ifdef DEBUG_OVERLAY_DIFF_EN
      if (!grid_c && ch_valid_c && (bit_c != prev_word_c[bit_idx_c])) begin
        rgb_d = bit_c ? RGB_DIFF_SET : RGB_DIFF_CLR;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ov_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      in_ov_q <= in_ov_d;
      rgb_q   <= rgb_d;
    end
  end

  assign in_debug_overlay = in_ov_q;
  assign debug_rgb        = rgb_q;

endmodule
